bbox_test_scheduler: RTL and testbench

//  Shares one ray_bbox_intersect pipeline between NUM_REQ traversal requesters.
//  - Round-robin arbitration decides which requester issues each cycle.
//  - Drives the datapath mux select and the pipeline stall.
//  - A shadow pipeline carries {requester, id} alongside the intersect

---
 rtl/bbox_test_scheduler.sv | 114 +++++++++++
 tb/tb_bbox_test_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_test_scheduler.sv
// Round-robin issue scheduler sharing one ray_bbox_intersect pipeline between
// NUM_REQ requesters, with a shadow {req, id} pipeline and a registered response port.
module bbox_test_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_W    = 2,
    parameter int ID_W     = 4,
    parameter int PIPE_LAT = 1,
    parameter int DATA_W   = 49
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ID_W-1:0]    req_id,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [REQ_W-1:0]           issue_sel,
    output logic                       pipe_stall,
    input  logic                       pipe_hit,
    input  logic signed [DATA_W-1:0]   pipe_dist,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [REQ_W-1:0]           rsp_req,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_hit,
    output logic signed [DATA_W-1:0]   rsp_dist,
    output logic                       busy
);

    logic [REQ_W-1:0]    ptr_q;
    logic [REQ_W-1:0]    sel_q;
    logic [REQ_W-1:0]    grant;
    logic                any_valid;
    logic                issue;

    logic [PIPE_LAT-1:0] vld_p;
    logic [REQ_W-1:0]    req_p [PIPE_LAT];
    logic [ID_W-1:0]     id_p  [PIPE_LAT];

    // First valid requester after p, wrapping modulo NUM_REQ; returns p if none.
    function automatic logic [REQ_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [REQ_W-1:0]   p);
        logic [REQ_W-1:0] cand;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = REQ_W'((int'(p) + k) % NUM_REQ);
            if (!found && v[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign pipe_stall = rsp_valid & ~rsp_ready;
    assign any_valid  = |req_valid;
    assign grant      = rr_pick(req_valid, ptr_q);
    assign issue      = any_valid & ~pipe_stall;
    assign issue_sel  = any_valid ? grant : sel_q;
    assign busy       = (|vld_p) | rsp_valid;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Control state: arbitration pointer, shadow valids, response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= REQ_W'(NUM_REQ - 1);
            sel_q     <= '0;
            vld_p     <= '0;
            rsp_valid <= 1'b0;
            rsp_req   <= '0;
            rsp_id    <= '0;
            rsp_hit   <= 1'b0;
            rsp_dist  <= '0;
        end else begin
            if (any_valid) begin
                sel_q <= grant;
            end
            if (!pipe_stall) begin
                if (issue) begin
                    ptr_q <= grant;
                end
                vld_p[0] <= issue;
                for (int s = 1; s < PIPE_LAT; s++) begin
                    vld_p[s] <= vld_p[s-1];
                end
                rsp_valid <= vld_p[PIPE_LAT-1];
                if (vld_p[PIPE_LAT-1]) begin
                    rsp_req  <= req_p[PIPE_LAT-1];
                    rsp_id   <= id_p[PIPE_LAT-1];
                    rsp_hit  <= pipe_hit;
                    rsp_dist <= pipe_dist;
                end
            end
        end
    end

    // Shadow data stages: masked by vld_p, so left out of reset
    always_ff @(posedge clk) begin
        if (!pipe_stall) begin
            req_p[0] <= grant;
            id_p[0]  <= req_id[int'(grant)*ID_W +: ID_W];
            for (int s = 1; s < PIPE_LAT; s++) begin
                req_p[s] <= req_p[s-1];
                id_p[s]  <= id_p[s-1];
            end
        end
    end

endmodule

// File: tb/tb_bbox_test_scheduler.sv
// Directed bench for bbox_test_scheduler with a one-stage behavioural
// stand-in for the intersect datapath, selected by issue_sel.
module tb_bbox_test_scheduler;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 2;
    localparam int ID_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ID_W-1:0]   req_id = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [REQ_W-1:0]          issue_sel;
    logic                      pipe_stall;
    logic                      pipe_hit;
    logic signed [48:0]        pipe_dist;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b1;
    logic [REQ_W-1:0]          rsp_req;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_hit;
    logic signed [48:0]        rsp_dist;
    logic                      busy;

    // Per-requester intersect outcome for the ray/box pair each one presents
    logic [NUM_REQ-1:0]        hit_tab = '0;
    logic signed [48:0]        dist_tab [NUM_REQ];

    int total = 0;
    int bad   = 0;

    bbox_test_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .issue_sel (issue_sel),
        .pipe_stall(pipe_stall),
        .pipe_hit  (pipe_hit),
        .pipe_dist (pipe_dist),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_req   (rsp_req),
        .rsp_id    (rsp_id),
        .rsp_hit   (rsp_hit),
        .rsp_dist  (rsp_dist),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Intersect stand-in: one register stage, clock-enabled by ~pipe_stall, not reset
    always @(posedge clk) begin
        if (!pipe_stall) begin
            pipe_hit  <= hit_tab[issue_sel];
            pipe_dist <= dist_tab[issue_sel];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] acc;
        int got_q[$];

        for (int i = 0; i < NUM_REQ; i++) dist_tab[i] = '0;

        // Test 1: single request, box contains ray
        do_reset;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_rsp_dist", rsp_dist, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ready", req_ready, 0);
        hit_tab[0]   = 1'b1;
        dist_tab[0]  = 49'd1234;
        req_id[3:0]  = 4'd5;
        req_valid    = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_sel", issue_sel, 0);
        tick;
        req_valid = '0;
        #1;
        chk("t1_c1_valid", rsp_valid, 0);
        chk("t1_c1_busy", busy, 1);
        tick;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_req", rsp_req, 0);
        chk("t1_rsp_id", rsp_id, 5);
        chk("t1_rsp_hit", rsp_hit, 1);
        chk("t1_rsp_dist", rsp_dist, 1234);
        tick;
        chk("t1_done_valid", rsp_valid, 0);
        chk("t1_done_busy", busy, 0);

        // Test 2: all four valid for 8 cycles, rotation and 1 result/cycle
        do_reset;
        req_id  = {4'd11, 4'd10, 4'd9, 4'd8};
        hit_tab = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) dist_tab[i] = 49'(100 * i + 7);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            #1;
            if (k < 8) begin
                chk("t2_ready", req_ready, 4'b0001 << (k % 4));
                chk("t2_sel", issue_sel, k % 4);
            end
            if (k >= 2) begin
                chk("t2_rsp_valid", rsp_valid, 1);
                chk("t2_rsp_req", rsp_req, (k - 2) % 4);
                chk("t2_rsp_id", rsp_id, 8 + (k - 2) % 4);
                chk("t2_rsp_dist", rsp_dist, 100 * ((k - 2) % 4) + 7);
            end
            tick;
        end
        #1;
        chk("t2_drain_valid", rsp_valid, 0);

        // Test 3: four issues, consumer stalls three cycles
        do_reset;
        pend = 4'b1111;
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            req_valid = pend;
            rsp_ready = !(c >= 2 && c <= 4);
            #1;
            if (c >= 2 && c <= 4) begin
                chk("t3_stall", pipe_stall, 1);
                chk("t3_ready_low", req_ready, 0);
                chk("t3_hold_valid", rsp_valid, 1);
                chk("t3_hold_req", rsp_req, 0);
                chk("t3_hold_id", rsp_id, 8);
            end
            acc = req_ready & pend;
            if (rsp_valid && rsp_ready) got_q.push_back(int'(rsp_req));
            tick;
            pend = pend & ~acc;
        end
        req_valid = '0;
        chk("t3_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++) chk("t3_order", got_q[i], i);
        chk("t3_busy", busy, 0);

        // Test 4: ray parallel to x with origin outside the x slab -> miss
        do_reset;
        req_id[11:8] = 4'hA;
        hit_tab[2]   = 1'b0;
        dist_tab[2]  = 49'h1_2345_6789;
        req_valid    = 4'b0100;
        #1;
        chk("t4_ready", req_ready, 4'b0100);
        chk("t4_sel", issue_sel, 2);
        tick;
        req_valid = '0;
        tick;
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_req", rsp_req, 2);
        chk("t4_rsp_id", rsp_id, 4'hA);
        chk("t4_rsp_hit", rsp_hit, 0);
        tick;

        // Test 5: reset with two in flight and a held response
        do_reset;
        hit_tab   = 4'b1111;
        req_valid = 4'b1111;
        tick;
        tick;
        rsp_ready = 1'b0;
        #1;
        chk("t5_pre_valid", rsp_valid, 1);
        chk("t5_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", rsp_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_stall", pipe_stall, 0);
        rsp_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_prio_ready", req_ready, 4'b0001);
        chk("t5_prio_sel", issue_sel, 0);
        tick;
        tick;
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_req", rsp_req, 0);
        req_valid = '0;
        repeat (3) tick;

        // Test 6: requesters 1 and 3 with ptr=1; pointer moves only on issue
        do_reset;
        hit_tab[1]  = 1'b1;
        req_id[7:4] = 4'd3;
        req_valid   = 4'b0010;
        #1;
        chk("t6_c0_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        #1;
        chk("t6_hold_sel", issue_sel, 1);
        chk("t6_idle_ready", req_ready, 0);
        tick;
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("t6_stall", pipe_stall, 1);
        chk("t6_stall_sel", issue_sel, 3);
        chk("t6_stall_ready", req_ready, 0);
        tick;
        rsp_ready = 1'b1;
        #1;
        chk("t6_g3_sel", issue_sel, 3);
        chk("t6_g3_ready", req_ready, 4'b1000);
        tick;
        req_valid = 4'b0010;
        #1;
        chk("t6_g1_sel", issue_sel, 1);
        chk("t6_g1_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        repeat (4) tick;
        chk("t6_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
